exception_unit: RTL and testbench
=================================

# exception_unit

Parametrised exception controller for the multicycle MIPS core; it replaces the fixed two-cause Cause/EPC/interruption-address logic. It latches up to NUM_SRC exception events, applies a mask and fixed priority, and requests service from the control unit through a req/ack handshake. On acceptance it captures EPC and Cause and produces the memory address of the handler vector. It then blocks further requests until the control unit signals exception return.

## Interface
- WIDTH, 32, datapath width of pc_cur, epc, cause and vec_addr
- NUM_SRC, 4, number of exception sources; index 0 is opcode inexistente, index 1 is overflow, higher indices are free
- VEC_BASE, 253, vector-table base address in memory
- VEC_STRIDE, 1, address step between consecutive vector entries
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- src_evt  in  NUM_SRC  one-cycle event pulses, one bit per source
- src_mask  in  NUM_SRC  1 enables the source for requesting; pending bits latch regardless of mask
- pc_cur  in  WIDTH  current PC value, sampled on accept
- exc_ack  in  1  control unit accepts the request; meaningful only in REQ
- eret  in  1  return-from-exception pulse; meaningful only in HANDLER
- exc_req  out  1  request to the control unit
- in_handler  out  1  high while state is HANDLER
- pend  out  NUM_SRC  latched pending events
- epc  out  WIDTH  captured exception PC
- cause  out  WIDTH  index of the captured source, zero-extended
- vec_addr  out  WIDTH  VEC_BASE + cause*VEC_STRIDE, truncated to WIDTH

## Operation
- Pending register: each cycle, pend <= (pend & ~clr) | src_evt.
  - clr is the one-hot of the selected source on an accept cycle, otherwise zero.
  - If a source sets and clears in the same cycle, the set wins.
- Selection: sel = lowest index i with pend[i] & src_mask[i]. Selection is combinational on registered pend.
- FSM states: IDLE, REQ, HANDLER. The state is encoded in 2 bits; the unused encoding returns to IDLE.
- IDLE
  - Go to REQ when (pend & src_mask) != 0.
  - Otherwise stay in IDLE.
- REQ
  - exc_req = 1.
  - If exc_ack = 1:
    - epc <= pc_cur (adjusted per Configuration).
    - cause <= sel.
    - Clear pend[sel].
    - Go to HANDLER.
  - Else if (pend & src_mask) == 0, because the mask was changed: drop exc_req and go to IDLE.
  - Otherwise stay in REQ.
  - The ack wins over a same-cycle mask change only when the mask still enables sel.
- HANDLER
  - in_handler = 1 and exc_req = 0.
  - New events keep latching into pend.
  - On eret go to IDLE. Surviving pending events re-request through the normal IDLE path.
- Ignored inputs: eret outside HANDLER and exc_ack outside REQ.
- Capture: epc and cause change only on accept and hold otherwise. vec_addr is combinational from the cause register.
- Arithmetic: index and vector address are computed at WIDTH bits, modulo 2^WIDTH. The PC adjustment wraps modulo 2^WIDTH.

## Timing
- Reset values: state IDLE, pend = 0, epc = 0, cause = 0, exc_req = 0, in_handler = 0, vec_addr = VEC_BASE.
  - Reset mid-operation in any state discards all pending events and captured values.
  - Reset has priority over src_evt in the same cycle.
- Event latency:
  - src_evt is sampled at edge E0; pend is visible after E0.
  - State moves to REQ at E1, so exc_req is high from E1.
  - The minimum event-to-request latency is 2 edges.
- Accept: exc_ack is sampled high at edge Ea. epc, cause and vec_addr are valid and in_handler = 1 after Ea; exc_req falls after Ea.
- Return: eret is sampled at edge Er and the state is IDLE after Er. A still-pending enabled source re-asserts exc_req after Er+1.
- exc_req is a registered-state decode and is glitch-free within a cycle.

## Configuration
- EXC_PCADJ_EN defined: epc captures pc_cur − 4. This is for use when the PC has already been incremented in the fetch state.
- EXC_PCADJ_EN undefined: epc captures pc_cur unchanged.

## Test plan
- Reset, then pulse src_evt = 4'b0010 with mask = 4'b1111 and pc_cur = 32'h40, then ack in REQ -> exc_req high 2 edges after the event; after ack cause = 1 and vec_addr = 254. epc = 32'h3C with EXC_PCADJ_EN and 32'h40 without it.
- Pulse src_evt = 4'b0011 simultaneously, ack, eret -> first capture cause = 0 with pend = 4'b0010. After eret, exc_req re-asserts and the second capture gives cause = 1.
- mask = 4'b1101, pulse src_evt bit 1 -> no exc_req and pend = 4'b0010. Set mask = 4'b1111 -> exc_req after 1 edge.
- In REQ with only bit 1 pending, clear mask bit 1 without ack -> exc_req drops after 1 edge, state IDLE, pend keeps bit 1.
- In HANDLER, pulse bit 0 on the same cycle as an ack-cleared bit, and pulse exc_ack again -> the pend bit stays set and the extra ack has no effect. eret in IDLE has no effect.
- Assert reset while in HANDLER with pend = 4'b0101 -> all outputs return to reset values, vec_addr = 253.

Source files
------------

// File: rtl/exception_unit.sv
// Exception controller: latches events, selects one by mask and priority,
// and hands it to the control unit. Optional macro: EXC_PCADJ_EN (epc = pc_cur - 4).
module exception_unit #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 4,
    parameter int VEC_BASE   = 253,
    parameter int VEC_STRIDE = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_evt,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic [WIDTH-1:0]   pc_cur,
    input  logic               exc_ack,
    input  logic               eret,
    output logic               exc_req,
    output logic               in_handler,
    output logic [NUM_SRC-1:0] pend,
    output logic [WIDTH-1:0]   epc,
    output logic [WIDTH-1:0]   cause,
    output logic [WIDTH-1:0]   vec_addr
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [WIDTH-1:0] VecBase   = WIDTH'(VEC_BASE);
    localparam logic [WIDTH-1:0] VecStride = WIDTH'(VEC_STRIDE);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        HANDLER = 2'b10
    } stateType;

    stateType           state;
    logic               excReqQ;
    logic               inHandlerQ;
    logic [NUM_SRC-1:0] pendQ;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr;
    logic [IDXW-1:0]    selIdx;
    logic               anyActive;
    logic               accept;
    logic [WIDTH-1:0]   pcCap;
    logic [WIDTH-1:0]   epcQ;
    logic [WIDTH-1:0]   causeQ;

    assign active    = pendQ & src_mask;
    assign anyActive = |active;
    assign accept    = (state == REQ) && exc_ack && anyActive;
    assign clr       = accept ? (NUM_SRC'(1) << selIdx) : '0;

`ifdef EXC_PCADJ_EN
    assign pcCap = pc_cur - WIDTH'(4);
`else
    assign pcCap = pc_cur;
`endif

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        selIdx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) selIdx = IDXW'(i);
        end
    end

    // Pending latch; a same-cycle event beats the accept clear.
    always_ff @(posedge clock) begin
        if (reset) pendQ <= '0;
        else       pendQ <= (pendQ & ~clr) | src_evt;
    end

    // EPC and Cause capture only on accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            epcQ   <= '0;
            causeQ <= '0;
        end else if (accept) begin
            epcQ   <= pcCap;
            causeQ <= WIDTH'(selIdx);
        end
    end

    // Request/handler FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            excReqQ    <= 1'b0;
            inHandlerQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyActive) begin
                        state   <= REQ;
                        excReqQ <= 1'b1;
                    end
                end
                REQ: begin
                    if (accept) begin
                        state      <= HANDLER;
                        excReqQ    <= 1'b0;
                        inHandlerQ <= 1'b1;
                    end else if (!anyActive) begin
                        state   <= IDLE;
                        excReqQ <= 1'b0;
                    end
                end
                HANDLER: begin
                    if (eret) begin
                        state      <= IDLE;
                        inHandlerQ <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    excReqQ    <= 1'b0;
                    inHandlerQ <= 1'b0;
                end
            endcase
        end
    end

    assign exc_req    = excReqQ;
    assign in_handler = inHandlerQ;
    assign pend       = pendQ;
    assign epc        = epcQ;
    assign cause      = causeQ;
    assign vec_addr   = VecBase + causeQ * VecStride;

endmodule

// File: tb/tb_exception_unit.sv
// Randomized bench for exception_unit with a cycle-level reference model
// and directed literal checks.
module tb_exception_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  src_evt;
    logic [3:0]  src_mask;
    logic [31:0] pc_cur;
    logic        exc_ack;
    logic        eret;
    logic        exc_req;
    logic        in_handler;
    logic [3:0]  pend;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] vec_addr;

    int nCmp = 0;
    int nBad = 0;
    bit checkEn = 0;

`ifdef EXC_PCADJ_EN
    localparam logic [31:0] ExpEpc = 32'h3C;
`else
    localparam logic [31:0] ExpEpc = 32'h40;
`endif

    // Model: mode 0 waiting, 1 requesting, 2 in handler.
    int          mMode;
    logic [3:0]  mPend;
    logic [31:0] mEpc;
    logic [31:0] mCause;

    exception_unit dut (
        .clock(clock),
        .reset(reset),
        .src_evt(src_evt),
        .src_mask(src_mask),
        .pc_cur(pc_cur),
        .exc_ack(exc_ack),
        .eret(eret),
        .exc_req(exc_req),
        .in_handler(in_handler),
        .pend(pend),
        .epc(epc),
        .cause(cause),
        .vec_addr(vec_addr)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on each rising edge.
    always @(posedge clock) begin
        int low;
        logic [3:0] en;
        if (reset) begin
            mMode = 0; mPend = 0; mEpc = 0; mCause = 0;
        end else begin
            en = mPend & src_mask;
            low = -1;
            for (int i = 3; i >= 0; i--) if (en[i]) low = i;
            if (mMode == 0) begin
                if (low >= 0) mMode = 1;
            end else if (mMode == 1) begin
                if (low < 0) mMode = 0;
                else if (exc_ack) begin
                    mMode = 2;
                    mCause = low;
`ifdef EXC_PCADJ_EN
                    mEpc = pc_cur - 32'd4;
`else
                    mEpc = pc_cur;
`endif
                    mPend[low] = 1'b0;
                end
            end else if (eret) begin
                mMode = 0;
            end
            mPend = mPend | src_evt;
        end
    end

    // Compare every cycle once reset has been applied.
    always @(negedge clock) begin
        if (checkEn) begin
            check("m_exc_req", 32'(exc_req), 32'(mMode == 1));
            check("m_in_handler", 32'(in_handler), 32'(mMode == 2));
            check("m_pend", 32'(pend), 32'(mPend));
            check("m_epc", epc, mEpc);
            check("m_cause", cause, mCause);
            check("m_vec_addr", vec_addr, 32'd253 + mCause);
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        reset = 1; src_evt = 0; src_mask = 4'hF;
        pc_cur = 0; exc_ack = 0; eret = 0;
        repeat (2) cyc();
        checkEn = 1;
        check("rst_req", 32'(exc_req), 0);
        check("rst_vec", vec_addr, 32'd253);
        check("rst_epc", epc, 0);
        check("rst_pend", 32'(pend), 0);
        reset = 0;

        // single event, ack
        src_evt = 4'b0010; pc_cur = 32'h40;
        cyc(); src_evt = 0;
        check("t1_req_e0", 32'(exc_req), 0);
        check("t1_pend_e0", 32'(pend), 32'h2);
        cyc();
        check("t1_req_e1", 32'(exc_req), 1);
        exc_ack = 1;
        cyc(); exc_ack = 0;
        check("t1_cause", cause, 32'd1);
        check("t1_vec", vec_addr, 32'd254);
        check("t1_epc", epc, ExpEpc);
        check("t1_inh", 32'(in_handler), 1);
        check("t1_req_off", 32'(exc_req), 0);
        eret = 1;
        cyc(); eret = 0;

        // two simultaneous events, priority
        src_evt = 4'b0011;
        cyc(); src_evt = 0;
        cyc();
        check("t2_req", 32'(exc_req), 1);
        exc_ack = 1;
        cyc(); exc_ack = 0;
        check("t2_cause0", cause, 0);
        check("t2_pend0", 32'(pend), 32'h2);
        eret = 1;
        cyc(); eret = 0;
        check("t2_idle", 32'(exc_req), 0);
        cyc();
        check("t2_rereq", 32'(exc_req), 1);
        exc_ack = 1;
        cyc(); exc_ack = 0;
        check("t2_cause1", cause, 32'd1);
        check("t2_pend1", 32'(pend), 0);
        eret = 1;
        cyc(); eret = 0;

        // masked source latches but does not request
        src_mask = 4'b1101; src_evt = 4'b0010;
        cyc(); src_evt = 0;
        cyc();
        check("t3_noreq", 32'(exc_req), 0);
        check("t3_pend", 32'(pend), 32'h2);
        src_mask = 4'hF;
        cyc();
        check("t3_req", 32'(exc_req), 1);

        // mask withdrawn while requesting
        src_mask = 4'b1101;
        cyc();
        check("t4_drop", 32'(exc_req), 0);
        check("t4_inh", 32'(in_handler), 0);
        check("t4_pend", 32'(pend), 32'h2);
        src_mask = 4'hF;
        cyc();
        exc_ack = 1;
        cyc(); exc_ack = 0;
        check("t4_cause", cause, 32'd1);
        eret = 1;
        cyc(); eret = 0;

        // set beats clear; stray ack and eret ignored
        src_evt = 4'b0001;
        cyc(); src_evt = 0;
        cyc();
        check("t5_req", 32'(exc_req), 1);
        exc_ack = 1; src_evt = 4'b0001;
        cyc(); exc_ack = 0; src_evt = 0;
        check("t5_cause", cause, 0);
        check("t5_pend", 32'(pend), 32'h1);
        exc_ack = 1;
        cyc(); exc_ack = 0;
        check("t5_ack_hnd", 32'(in_handler), 1);
        check("t5_ack_pend", 32'(pend), 32'h1);
        src_mask = 0; eret = 1;
        cyc(); eret = 0;
        check("t5_ret", 32'(in_handler), 0);
        eret = 1;
        cyc(); eret = 0;
        check("t5_idle_eret", 32'(exc_req), 0);
        check("t5_idle_inh", 32'(in_handler), 0);

        // reset from handler
        src_mask = 4'hF;
        cyc();
        check("t6_req", 32'(exc_req), 1);
        exc_ack = 1; src_evt = 4'b0101;
        cyc(); exc_ack = 0; src_evt = 0;
        check("t6_pend", 32'(pend), 32'h5);
        check("t6_inh", 32'(in_handler), 1);
        reset = 1;
        cyc(); reset = 0;
        check("t6_rst_inh", 32'(in_handler), 0);
        check("t6_rst_pend", 32'(pend), 0);
        check("t6_rst_vec", vec_addr, 32'd253);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            src_evt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 7) == 0) src_mask = 4'($urandom);
            exc_ack = 1'($urandom_range(0, 1));
            eret = ($urandom_range(0, 3) == 0);
            pc_cur = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0; src_evt = 0; exc_ack = 0; eret = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
